// File: rtl/out_port.sv
// -----------------------------------------------------------------------------
// out_port
//   Output port stage fed by the control unit's OUT state. Every out_write
//   captures the bus into a live display copy (out_reg) and queues the word
//   for an external consumer over a valid/ready handshake. Queue storage is
//   the output register plus a circular buffer of DEPTH-1 entries, so the
//   total capacity is DEPTH words. A write that finds the queue full and no
//   pop in the same cycle is dropped (out_reg still updates).
//
//   Optional feature macro: OUT_PORT_STATUS_EN
//     defined   : out_level reports occupancy, overflow is a sticky drop flag
//                 (set wins over ovf_clr), ovf_clr is honoured.
//     undefined : out_level and overflow read 0, ovf_clr is ignored; queue
//                 behaviour and timing are identical.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   out_write  in   capture strobe
//   bus        in   [DATA_W-1:0] system bus
//   out_reg    out  [DATA_W-1:0] last captured word
//   out_data   out  [DATA_W-1:0] head-of-queue word
//   out_valid  out  out_data is valid
//   out_ready  in   consumer accepts out_data
//   out_level  out  [$clog2(DEPTH):0] words held, 0..DEPTH
//   overflow   out  sticky dropped-capture flag
//   ovf_clr    in   clears overflow
// -----------------------------------------------------------------------------
module out_port #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     out_write,
   input  logic [DATA_W-1:0]        bus,
   output logic [DATA_W-1:0]        out_reg,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   out_level,
   output logic                     overflow,
   input  logic                     ovf_clr
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   localparam logic [PW-1:0] BUF_CAP  = PW'(DEPTH - 1);  // buffer entries
   localparam logic [PW-1:0] BUF_LAST = PW'(DEPTH - 2);  // last buffer index

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

   // Circular-buffer pointer advance with wrap at the last entry; the buffer
   // holds DEPTH-1 entries, so the wrap is explicit rather than natural.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      logic [PW-1:0] r;
      if (p == BUF_LAST) begin
         r = '0;
      end else begin
         r = p + PW'(1);
      end
      return r;
   endfunction

   logic [DATA_W-1:0] mem [0:DEPTH-2];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     buf_cnt;
   logic [0:0]        state;

   logic [0:0]        state_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic [PW-1:0]     wr_nxt;
   logic [PW-1:0]     rd_nxt;
   logic [PW-1:0]     cnt_nxt;
   logic              mem_we;
   logic              drop;
   logic              pop;

   assign pop       = out_valid & out_ready;
   assign out_valid = (state == ST_HOLD);

   // Next-state decode for the output stage and circular buffer.
   always_comb begin
      state_nxt = state;
      data_nxt  = out_data;
      wr_nxt    = wr_ptr;
      rd_nxt    = rd_ptr;
      cnt_nxt   = buf_cnt;
      mem_we    = 1'b0;
      drop      = 1'b0;
      case (state)
         ST_EMPTY: begin
            // Buffer is necessarily empty here: bypass straight to the output.
            if (out_write) begin
               data_nxt  = bus;
               state_nxt = ST_HOLD;
            end else begin
               state_nxt = ST_EMPTY;
            end
         end
         ST_HOLD: begin
            if (pop) begin
               if (buf_cnt == '0) begin
                  if (out_write) begin
                     data_nxt = bus;
                  end else begin
                     state_nxt = ST_EMPTY;
                  end
               end else begin
                  data_nxt = mem[rd_ptr];
                  rd_nxt   = ptr_inc(rd_ptr);
                  // With the buffer full, rd_ptr == wr_ptr: the head is read
                  // out before the non-blocking write replaces it.
                  if (out_write) begin
                     mem_we = 1'b1;
                     wr_nxt = ptr_inc(wr_ptr);
                  end else begin
                     cnt_nxt = buf_cnt - PW'(1);
                  end
               end
            end else begin
               if (out_write) begin
                  if (buf_cnt == BUF_CAP) begin
                     drop = 1'b1;
                  end else begin
                     mem_we  = 1'b1;
                     wr_nxt  = ptr_inc(wr_ptr);
                     cnt_nxt = buf_cnt + PW'(1);
                  end
               end else begin
                  state_nxt = ST_HOLD;
               end
            end
         end
         default: begin
            state_nxt = ST_EMPTY;
         end
      endcase
   end

   // Output stage, pointers, occupancy and display copy.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_EMPTY;
         out_data <= '0;
         out_reg  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         buf_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         out_data <= data_nxt;
         wr_ptr   <= wr_nxt;
         rd_ptr   <= rd_nxt;
         buf_cnt  <= cnt_nxt;
         if (out_write) begin
            out_reg <= bus;
         end else begin
            out_reg <= out_reg;
         end
      end
   end

   // Buffer storage; contents are qualified by buf_cnt so no reset is needed.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_ptr] <= bus;
      end else begin
         mem[wr_ptr] <= mem[wr_ptr];
      end
   end

`ifdef OUT_PORT_STATUS_EN
   logic [LW-1:0] level;
   logic          ovf;

   assign out_level = level;
   assign overflow  = ovf;

   // Registered occupancy and sticky overflow; a drop beats a clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         level <= '0;
         ovf   <= 1'b0;
      end else begin
         level <= {1'b0, cnt_nxt} + {{PW{1'b0}}, state_nxt};
         if (drop) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end else begin
            ovf <= ovf;
         end
      end
   end
`else
   logic [1:0] unused_status;

   assign unused_status = {ovf_clr, drop};
   assign out_level     = {LW{1'b0}};
   assign overflow      = 1'b0;
`endif

endmodule

// File: tb/tb_out_port.sv
// -----------------------------------------------------------------------------
// tb_out_port
//   Self-checking bench for out_port. A queue-based reference model tracks
//   the words the block should hold, the display copy and the overflow flag.
//   Directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_out_port;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 8;
   localparam int LW     = $clog2(DEPTH) + 1;

`ifdef OUT_PORT_STATUS_EN
   localparam bit STATUS = 1'b1;
`else
   localparam bit STATUS = 1'b0;
`endif

   logic              clk;
   logic              rst;
   logic              out_write;
   logic [DATA_W-1:0] bus;
   logic [DATA_W-1:0] out_reg;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic [LW-1:0]     out_level;
   logic              overflow;
   logic              ovf_clr;

   out_port #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .out_write (out_write),
      .bus       (bus),
      .out_reg   (out_reg),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_level (out_level),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DATA_W-1:0] q [$];
   logic [DATA_W-1:0] m_reg;
   logic              m_ovf;
   logic              after_rst;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
      end
   endtask

   // One clock cycle: drive at the falling edge, advance the model at the
   // rising edge, compare shortly after.
   task automatic step(input logic w, input logic [DATA_W-1:0] b, input logic r,
                       input logic c, input logic rs);
      bit pop_now;
      bit full_now;
      bit set_now;
      @(negedge clk);
      out_write = w;
      bus       = b;
      out_ready = r;
      ovf_clr   = c;
      rst       = rs;
      @(posedge clk);
      if (rs) begin
         q.delete();
         m_reg     = '0;
         m_ovf     = 1'b0;
         after_rst = 1'b1;
      end else begin
         after_rst = 1'b0;
         pop_now   = (q.size() != 0) && r;
         full_now  = (q.size() == DEPTH);
         set_now   = w && full_now && !pop_now;
         if (w) m_reg = b;
         if (pop_now) void'(q.pop_front());
         if (w && !set_now) q.push_back(b);
         if (set_now) m_ovf = 1'b1;
         else if (c) m_ovf = 1'b0;
      end
      #1;
      check("valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) begin
         check("data", {16'd0, out_data}, {16'd0, q[0]});
      end else if (after_rst) begin
         check("data_rst", {16'd0, out_data}, 32'd0);
      end
      check("out_reg", {16'd0, out_reg}, {16'd0, m_reg});
      check("level", {{(32-LW){1'b0}}, out_level}, STATUS ? q.size() : 32'd0);
      check("overflow", {31'd0, overflow}, {31'd0, STATUS & m_ovf});
   endtask

   initial begin
      rst       = 1'b1;
      out_write = 1'b0;
      bus       = '0;
      out_ready = 1'b0;
      ovf_clr   = 1'b0;
      q.delete();
      m_reg     = '0;
      m_ovf     = 1'b0;
      after_rst = 1'b0;

      // Reset state.
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

      // Single word with consumer always ready.
      step(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

      // Fill past capacity with the consumer stalled, then drain.
      for (int i = 1; i <= 9; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

      // Write and pop together while full.
      for (int i = 1; i <= 8; i++) step(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

      // Clear coinciding with an overflowing write, then clear alone.
      for (int i = 1; i <= 8; i++) step(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

      // Level-1 write+pop with an empty buffer keeps valid high.
      for (int i = 0; i < 8; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      step(1'b1, 16'hA001, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'hA002, 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

      // Stall with three words queued, pop once, then reset mid-drain.
      for (int i = 1; i <= 3; i++) step(1'b1, 16'(16'h0300 + i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

      // Randomized traffic with varying consumer speed.
      for (int i = 0; i < 1500; i++) begin
         int rbias;
         rbias = (i / 250) % 4;
         step(1'($urandom_range(0, 1)),
              16'($urandom()),
              1'($urandom_range(0, 3) < rbias),
              1'($urandom_range(0, 15) == 0),
              1'($urandom_range(0, 299) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
